// File: rtl/shift_pkg.sv
// ------------------------------------------------------------------
// shift_pkg : operation and FSM state encodings for shift_sequencer
// Revision  : 1.0
// ------------------------------------------------------------------
`default_nettype none

package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/shift_sequencer_if.sv
// ------------------------------------------------------------------
// shift_sequencer_if : start/busy/done request bus of the shift unit
// Revision           : 1.0
// ------------------------------------------------------------------
`default_nettype none

interface shift_sequencer_if #(
  parameter int WIDTH = 32
);
  localparam int SW = $clog2(WIDTH);

  logic             start;
  logic             abort;
  logic [1:0]       op;
  logic [WIDTH-1:0] x;
  logic [SW-1:0]    shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, abort, op, x, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, abort, op, x, shamt,
    output busy, done, result
  );

endinterface

`default_nettype wire

// File: rtl/shift_step.sv
// ------------------------------------------------------------------
// shift_step : combinational shift of work by n (0..STEP) bits per op
// Revision   : 1.0
// ------------------------------------------------------------------
`default_nettype none

module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int NW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] work,
  input  logic [1:0]       op,
  input  logic [NW-1:0]    n,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] w_srl;
  logic [WIDTH-1:0] w_fill_mask;

  assign w_srl       = work >> n;
  assign w_fill_mask = fill ? ~({WIDTH{1'b1}} >> n) : '0;

  // For ROR with n==0 the left shift is by WIDTH and contributes nothing.
  always_comb begin
    shifted = w_srl;
    case (op)
      OP_SLL:  shifted = work << n;
      OP_SRL:  shifted = w_srl;
      OP_SRA:  shifted = w_srl | w_fill_mask;
      default: shifted = w_srl | (work << (WIDTH - int'(n)));
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ------------------------------------------------------------------
// shift_sequencer : multi-cycle shifter, STEP bits per cycle, FSM-driven
// Revision        : 1.0
// ------------------------------------------------------------------
`default_nettype none

module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic              clk,
  input  logic              clr,
  shift_sequencer_if.slave  bus
);

  localparam int SW = $clog2(WIDTH);
  localparam int NW = $clog2(STEP + 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_shifted;
  logic [SW-1:0]    r_remaining;
  logic [SW-1:0]    w_remaining_next;
  logic             r_sign;
  logic [NW-1:0]    w_n;
  logic             w_last;
  logic             w_accept;

  always_comb begin
    if (int'(r_remaining) < STEP) w_n = NW'(r_remaining);
    else                          w_n = NW'(STEP);
  end

  assign w_remaining_next = r_remaining - SW'(w_n);
  assign w_last           = (w_remaining_next == '0);
  assign w_accept         = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.start;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .NW    (NW)
  ) u_step (
    .work    (r_work),
    .op      (r_op),
    .n       (w_n),
    .fill    (r_sign),
    .shifted (w_shifted)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Abort wins over completion: it is checked before the last-step test.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) w_state_next = (bus.shamt == '0) ? ST_DONE : ST_SHIFT;
        else           w_state_next = ST_IDLE;
      end
      ST_SHIFT: begin
        if (bus.abort)   w_state_next = ST_IDLE;
        else if (w_last) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_op        <= '0;
      r_work      <= '0;
      r_remaining <= '0;
      r_sign      <= 1'b0;
      r_result    <= '0;
    end else if (w_accept) begin
      r_op        <= bus.op;
      r_work      <= bus.x;
      r_remaining <= bus.shamt;
      r_sign      <= bus.x[WIDTH-1];
      if (bus.shamt == '0) r_result <= bus.x;
    end else if ((r_state == ST_SHIFT) && !bus.abort) begin
      r_work      <= w_shifted;
      r_remaining <= w_remaining_next;
      if (w_last) r_result <= w_shifted;
    end
  end

  always_comb begin
    bus.busy   = (r_state == ST_SHIFT);
    bus.done   = (r_state == ST_DONE);
    bus.result = r_result;
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ------------------------------------------------------------------
// tb_shift_sequencer : scoreboard bench for STEP=1 and STEP=4 instances
// Revision           : 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_shift_sequencer;
  import shift_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  logic [1:0]  rop;
  logic [31:0] rx;
  logic [4:0]  rsh;
  int          nb;
  int          target;
  int          guard;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_sequencer_if #(.WIDTH(32)) bus0 ();
  shift_sequencer_if #(.WIDTH(32)) bus1 ();

  shift_sequencer #(.WIDTH(32), .STEP(1)) u_dut0 (.clk(clk), .clr(clr), .bus(bus0.slave));
  shift_sequencer #(.WIDTH(32), .STEP(4)) u_dut1 (.clk(clk), .clr(clr), .bus(bus1.slave));

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input int s);
    case (op)
      OP_SLL:  return x << s;
      OP_SRL:  return x >> s;
      OP_SRA:  return 32'($signed(x) >>> s);
      default: return (s == 0) ? x : ((x >> s) | (x << (32 - s)));
    endcase
  endfunction

  function automatic int lat_of(input bit sel, input logic [4:0] sh);
    int step;
    step = sel ? 4 : 1;
    return (int'(sh) + step - 1) / step;
  endfunction

  function automatic int qsize(input bit sel);
    return sel ? q1.size() : q0.size();
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? bus1.busy : bus0.busy;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic [1:0] op,
                       input logic [31:0] x, input logic [4:0] sh);
    if (sel) begin
      bus1.start = st; bus1.op = op; bus1.x = x; bus1.shamt = sh;
    end else begin
      bus0.start = st; bus0.op = op; bus0.x = x; bus0.shamt = sh;
    end
  endtask

  // Called at a falling edge; returns just after the next falling edge.
  task automatic issue(input bit sel, input logic [1:0] op, input logic [31:0] x,
                       input logic [4:0] sh, input bit expect_done,
                       input logic [31:0] exp_res, output int first_busy);
    exp_t e;
    e.res = exp_res;
    e.cyc = cyc + 1 + lat_of(sel, sh);
    drive(sel, 1'b1, op, x, sh);
    if (expect_done) begin
      if (sel) q1.push_back(e);
      else     q0.push_back(e);
    end
    @(negedge clk);
    drive(sel, 1'b0, 2'($urandom), $urandom, 5'($urandom));
    #1;
    first_busy = busy_of(sel) ? 1 : 0;
  endtask

  task automatic wait_idle(input bit sel, input int nb_in, input int exp_busy);
    int n;
    n = nb_in;
    for (int i = 0; i < 200 && qsize(sel) != 0; i++) begin
      @(negedge clk);
      #1;
      if (busy_of(sel) === 1'b1) n++;
    end
    check_value(sel ? "dut1_drain" : "dut0_drain", 32'(qsize(sel)), 32'd0);
    check_value(sel ? "dut1_busy_cycles" : "dut0_busy_cycles", 32'(n), 32'(exp_busy));
  endtask

  task automatic run_op(input bit sel, input logic [1:0] op, input logic [31:0] x,
                        input logic [4:0] sh, input logic [31:0] exp_res);
    int b;
    issue(sel, op, x, sh, 1'b1, exp_res, b);
    wait_idle(sel, b, lat_of(sel, sh));
  endtask

  always @(negedge clk) begin
    if (bus0.done === 1'b1) begin
      if (q0.size() == 0) check_value("dut0_spurious_done", 32'(bus0.done), 32'd0);
      else begin
        m0 = q0.pop_front();
        check_value("dut0_result", bus0.result, m0.res);
        check_value("dut0_done_cycle", 32'(cyc), 32'(m0.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.done === 1'b1) begin
      if (q1.size() == 0) check_value("dut1_spurious_done", 32'(bus1.done), 32'd0);
      else begin
        m1 = q1.pop_front();
        check_value("dut1_result", bus1.result, m1.res);
        check_value("dut1_done_cycle", 32'(cyc), 32'(m1.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1;
    bus0.abort = 1'b0;
    bus1.abort = 1'b0;
    drive(1'b0, 1'b0, OP_SLL, 32'd0, 5'd0);
    drive(1'b1, 1'b0, OP_SLL, 32'd0, 5'd0);
    repeat (2) @(negedge clk);
    check_value("rst_busy0",   32'(bus0.busy), 32'd0);
    check_value("rst_done0",   32'(bus0.done), 32'd0);
    check_value("rst_result0", bus0.result,    32'd0);
    check_value("rst_busy1",   32'(bus1.busy), 32'd0);
    check_value("rst_done1",   32'(bus1.done), 32'd0);
    check_value("rst_result1", bus1.result,    32'd0);
    clr = 1'b0;
    @(negedge clk);

    run_op(1'b0, OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000);
    run_op(1'b0, OP_SRA, 32'h8000_00F0, 5'd4,  32'hF800_000F);
    run_op(1'b0, OP_SRL, 32'h8000_00F0, 5'd4,  32'h0800_000F);
    run_op(1'b0, OP_SRL, 32'h1234_5678, 5'd0,  32'h1234_5678);
    run_op(1'b1, OP_ROR, 32'h0000_00FF, 5'd8,  32'hFF00_0000);
    run_op(1'b1, OP_SLL, 32'h0000_0003, 5'd5,  32'h0000_0060);

    // Start pulse while busy must be ignored; then restart from DONE.
    target = cyc + 1 + 10;
    issue(1'b0, OP_SLL, 32'h0000_0001, 5'd10, 1'b1, 32'h0000_0400, nb);
    @(negedge clk);
    drive(1'b0, 1'b1, OP_SLL, 32'h0000_0003, 5'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, OP_SLL, 32'h0000_0003, 5'd1);
    guard = 0;
    while (cyc != target && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_value("b2b_reach_done", 32'(bus0.done), 32'd1);
    issue(1'b0, OP_SRL, 32'h0000_0080, 5'd3, 1'b1, 32'h0000_0010, nb);
    wait_idle(1'b0, nb, 3);

    // Abort mid-shift: no done pulse, result keeps the previous value.
    issue(1'b0, OP_SLL, 32'h0000_0005, 5'd20, 1'b0, 32'd0, nb);
    repeat (2) @(negedge clk);
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    #1;
    check_value("abort_busy",   32'(bus0.busy), 32'd0);
    check_value("abort_result", bus0.result,    32'h0000_0010);
    repeat (25) @(negedge clk);
    check_value("abort_result_held", bus0.result, 32'h0000_0010);

    // Asynchronous clear mid-shift, between clock edges.
    issue(1'b0, OP_SRA, 32'h8000_0000, 5'd20, 1'b0, 32'd0, nb);
    repeat (2) @(negedge clk);
    #1;
    check_value("pre_clr_busy", 32'(bus0.busy), 32'd1);
    clr = 1'b1;
    #1;
    check_value("clr_busy",   32'(bus0.busy), 32'd0);
    check_value("clr_done",   32'(bus0.done), 32'd0);
    check_value("clr_result", bus0.result,    32'd0);
    #1;
    clr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom);
      rx  = $urandom;
      rsh = (i % 5 == 0) ? 5'd0 : 5'($urandom);
      run_op(i[0], rop, rx, rsh, model(rop, rx, int'(rsh)));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
